alu_sweep_controller: RTL and testbench
=======================================

// Module: alu_sweep_controller
// PURPOSE
//  Exhaustive golden-vs-suspect sequencer for the 4-bit ALU.
//  - Steps every {op,A,B} combination (1024 vectors) into a golden ALU and a suspect ALU in lockstep.
//  - Compares their results, counts mismatches and captures the first failing vector.
//  - Sits between the trojan-detection test harness and the two ALU instances.
// PARAMETERS
//  WIDTH  4  operand/result width
//  OP_W   2  opcode width
//  LAT    0  ALU result latency in cycles (0..3); 0 = combinational ALUs
// PORTS
//  clk            in   1        single clock, rising edge
//  rst            in   1        synchronous, active-high reset
//  start          in   1        begin sweep; sampled in IDLE or DONE only
//  abort          in   1        cancel sweep; sampled in RUN/DRAIN
//  stop_on_first  in   1        config; sampled with start; end sweep at first mismatch
//  alu_a          out  WIDTH    operand A to both ALUs (registered)
//  alu_b          out  WIDTH    operand B to both ALUs (registered)
//  alu_op         out  OP_W     opcode to both ALUs (registered)
//  golden_result  in   WIDTH    result from reference ALU
//  dut_result     in   WIDTH    result from suspect ALU
//  busy           out  1        high in RUN and DRAIN
//  done           out  1        high in DONE (level, held until next start)
//  mismatch_cnt   out  VEC_W+1  mismatching vectors this sweep (11 b, max 1024)
//  ff_valid       out  1        first-fail capture valid
//  ff_a/ff_b      out  WIDTH    first failing A/B
//  ff_op          out  OP_W     first failing op
//  ff_diff        out  WIDTH    golden_result ^ dut_result at first fail
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; vector index 0; delay line empty.
//  - VEC_W = 2*WIDTH+OP_W = 10. Index idx[9:0] = {op,A,B}, B in LSBs, ascending from 0.
//  - FSM IDLE->RUN on start; clears mismatch_cnt, ff_*; latches stop_on_first.
//  - Timing: start sampled at edge t0. Vector k presented cycle t0+1+k.
//    Its results are compared during cycle t0+1+k+LAT and registered at that cycle's end.
//  - RUN: present one vector per cycle. After idx=1023 -> DRAIN (LAT>0) or DONE (LAT=0).
//  - DRAIN: alu_* hold last vector; compare remaining LAT in-flight vectors; then DONE.
//  - DONE: alu_* = 0, done=1, stats held. start -> RUN (new sweep, stats cleared).
//  - LAT=0: done rises 1025 cycles after the start edge; busy is high for exactly 1024+LAT cycles.
//  - Compare: mismatch iff golden_result != dut_result for a valid in-flight vector.
//    Increments mismatch_cnt. If ff_valid=0, captures vector into ff_* and sets ff_valid.
//  - stop_on_first=1: first mismatch -> DONE next cycle; later in-flight vectors discarded, not counted.
//  - abort in RUN/DRAIN -> IDLE next cycle: busy=0, done=0, stats retained, in-flight discarded.
//    abort outside RUN/DRAIN is ignored.
//  - start while busy is ignored. start and abort together while busy: abort wins.
//  - rst mid-sweep: immediate return to reset values next cycle; no partial done.
//  - mismatch_cnt cannot overflow (1024 fits in 11 b); no wrap logic.
// STRUCTURE
//  - Package alu_chk_pkg: state enum {IDLE,RUN,DRAIN,DONE}, OP_ADD/SUB/AND/OR codes, VEC_W, CNT_W.
//  - Sub-module vec_delay_line: LAT-deep shift register of {valid,op,A,B}.
//    LAT=0 degenerates to a wire. Aligns the issued vector with the returned results.
//  - Top holds the FSM, index counter, compare, counter and first-fail capture.
// TESTING
//  1. Golden vs golden, LAT=0, start pulse
//     -> done 1025 cycles after start; mismatch_cnt=0; ff_valid=0.
//  2. Golden vs trojan ALU (LSB flip when A=F,B=F), LAT=0
//     -> mismatch_cnt=4; ff_a=F, ff_b=F, ff_op=0, ff_diff=0001.
//  3. Same as 2 with stop_on_first=1
//     -> done 1 cycle after the idx=255 compare cycle; mismatch_cnt=1.
//  4. LAT=2 (registered ALU wrappers), golden vs trojan
//     -> mismatch_cnt=4; ff_* as in 2; busy high 1026 cycles; done 1027 cycles after start.
//  5. abort at vector 100 -> IDLE next cycle; done=0; busy=0.
//     A following start clears stats and completes a full sweep.
//  6. rst asserted at vector 500 -> all outputs 0 next cycle.
//     start while busy and start+abort together: abort wins, no restart.

Source files
------------

// File: rtl/alu_chk_pkg.sv
// Shared types and constants for the golden-vs-suspect ALU sweep controller.
package alu_chk_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int OP_W_DEF  = 2;
    localparam int VEC_W     = 2 * WIDTH_DEF + OP_W_DEF;
    localparam int CNT_W     = VEC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

endpackage

// File: rtl/vec_delay_line.sv
// LAT-deep shift register of {valid, vector}. It lines an issued vector up
// with the ALU results that come back LAT cycles later. LAT=0 is a wire.
module vec_delay_line #(
    parameter int LAT = 0,
    parameter int VW  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_vld,
    input  logic [VW-1:0] in_vec,
    output logic          out_vld,
    output logic [VW-1:0] out_vec
);

    if (LAT == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = clk ^ rst ^ flush;
        assign out_vld     = in_vld;
        assign out_vec     = in_vec;
    end else begin : g_shift
        logic [LAT-1:0] vld_q, vld_d;
        logic [VW-1:0]  vec_q [LAT];
        logic [VW-1:0]  vec_d [LAT];

        // Next contents: shift by one; a flush kills every in-flight vector.
        always_comb begin
            vld_d[0] = in_vld;
            vec_d[0] = in_vec;
            for (int i = 1; i < LAT; i++) begin
                vld_d[i] = vld_q[i-1];
                vec_d[i] = vec_q[i-1];
            end
            if (flush) begin
                vld_d = '0;
            end
        end

        // Only the valid bits need a reset; vector payload is qualified by them.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
            end else begin
                vld_q <= vld_d;
            end
            vec_q <= vec_d;
        end

        assign out_vld = vld_q[LAT-1];
        assign out_vec = vec_q[LAT-1];
    end

endmodule

// File: rtl/alu_sweep_controller.sv
// Steps every {op,A,B} vector into a golden and a suspect ALU, compares the
// returned results, counts mismatches and captures the first failing vector.
module alu_sweep_controller
    import alu_chk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OP_W  = 2,
    parameter int LAT   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    stop_on_first,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output logic [OP_W-1:0]         alu_op,
    input  logic [WIDTH-1:0]        golden_result,
    input  logic [WIDTH-1:0]        dut_result,
    output logic                    busy,
    output logic                    done,
    output logic [2*WIDTH+OP_W:0]   mismatch_cnt,
    output logic                    ff_valid,
    output logic [WIDTH-1:0]        ff_a,
    output logic [WIDTH-1:0]        ff_b,
    output logic [OP_W-1:0]         ff_op,
    output logic [WIDTH-1:0]        ff_diff
);

    localparam int            VW         = 2 * WIDTH + OP_W;
    localparam logic [VW-1:0] LAST_VEC   = '1;
    localparam logic [1:0]    DRAIN_INIT = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

    state_e           state_q, state_d;
    logic [VW-1:0]    vec_q, vec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             stop_q, stop_d;
    logic [VW:0]      cnt_q, cnt_d;
    logic             ffv_q, ffv_d;
    logic [VW-1:0]    ffvec_q, ffvec_d;
    logic [WIDTH-1:0] ffdiff_q, ffdiff_d;
    logic [1:0]       drain_q, drain_d;

    logic             issue_vld;
    logic             flush;
    logic             to_done;
    logic             miss;
    logic             dl_vld;
    logic [VW-1:0]    dl_vec;

    // A vector is live on the ALU inputs only while sweeping forward.
    assign issue_vld = (state_q == RUN);

    vec_delay_line #(
        .LAT (LAT),
        .VW  (VW)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .in_vld  (issue_vld),
        .in_vec  (vec_q),
        .out_vld (dl_vld),
        .out_vec (dl_vec)
    );

    // Sweep sequencing, result compare and first-fail capture.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        busy_d   = busy_q;
        done_d   = done_q;
        stop_d   = stop_q;
        cnt_d    = cnt_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;
        ffdiff_d = ffdiff_q;
        drain_d  = drain_q;
        flush    = 1'b0;
        to_done  = 1'b0;
        miss     = dl_vld && busy_q && (golden_result != dut_result);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    vec_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    stop_d   = stop_on_first;
                    cnt_d    = '0;
                    ffv_d    = 1'b0;
                    ffvec_d  = '0;
                    ffdiff_d = '0;
                end
            end
            RUN, DRAIN: begin
                if (abort) begin
                    // Abort beats start and beats any compare in this cycle.
                    state_d = IDLE;
                    vec_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    drain_d = '0;
                    flush   = 1'b1;
                end else begin
                    if (miss) begin
                        cnt_d = cnt_q + 1'b1;
                        if (!ffv_q) begin
                            ffv_d    = 1'b1;
                            ffvec_d  = dl_vec;
                            ffdiff_d = golden_result ^ dut_result;
                        end
                    end
                    if (miss && stop_q) begin
                        to_done = 1'b1;
                        flush   = 1'b1;
                    end else if (state_q == RUN) begin
                        if (vec_q == LAST_VEC) begin
                            if (LAT == 0) begin
                                to_done = 1'b1;
                            end else begin
                                state_d = DRAIN;
                                drain_d = DRAIN_INIT;
                            end
                        end else begin
                            vec_d = vec_q + 1'b1;
                        end
                    end else if (drain_q == 2'd0) begin
                        to_done = 1'b1;
                    end else begin
                        drain_d = drain_q - 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (to_done) begin
            state_d = DONE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            drain_d = '0;
        end
    end

    // State, registered outputs and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            stop_q   <= 1'b0;
            cnt_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
            ffdiff_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            stop_q   <= stop_d;
            cnt_q    <= cnt_d;
            ffv_q    <= ffv_d;
            ffvec_q  <= ffvec_d;
            ffdiff_q <= ffdiff_d;
            drain_q  <= drain_d;
        end
    end

    assign alu_b        = vec_q[WIDTH-1:0];
    assign alu_a        = vec_q[2*WIDTH-1:WIDTH];
    assign alu_op       = vec_q[VW-1:2*WIDTH];
    assign busy         = busy_q;
    assign done         = done_q;
    assign mismatch_cnt = cnt_q;
    assign ff_valid     = ffv_q;
    assign ff_b         = ffvec_q[WIDTH-1:0];
    assign ff_a         = ffvec_q[2*WIDTH-1:WIDTH];
    assign ff_op        = ffvec_q[VW-1:2*WIDTH];
    assign ff_diff      = ffdiff_q;

endmodule

// File: tb/tb_alu_sweep_controller.sv
// Scoreboard bench: two controllers (LAT=0 and LAT=2) driving bench ALU models.
module tb_alu_sweep_controller;

    typedef struct {
        int     dut;
        longint t0;
        int     lat;
        bit     done;
        int     cnt;
        bit     ffv;
        int     fa;
        int     fb;
        int     fop;
        int     fdiff;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start_v [2];
    logic        abort_v [2];
    logic        stop_cfg;
    logic [3:0]  a_w     [2];
    logic [3:0]  b_w     [2];
    logic [1:0]  op_w    [2];
    logic [3:0]  g_w     [2];
    logic [3:0]  s_w     [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [10:0] cnt_w   [2];
    logic        ffv_w   [2];
    logic [3:0]  ffa_w   [2];
    logic [3:0]  ffb_w   [2];
    logic [1:0]  ffop_w  [2];
    logic [3:0]  ffd_w   [2];

    logic        troj_en;
    logic [3:0]  trig_a, trig_b, mask;
    logic [3:0]  g_p1, s_p1, g_p2, s_p2;

    longint      cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        sbq [$];
    bit          bprev [2] = '{0, 0};
    int          blen  [2] = '{0, 0};

    function automatic logic [3:0] alu_gold(logic [1:0] op, logic [3:0] a, logic [3:0] b);
        case (op)
            2'd0:    return 4'(a + b);
            2'd1:    return 4'(a - b);
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [3:0] alu_susp(logic [1:0] op, logic [3:0] a, logic [3:0] b);
        logic [3:0] r;
        r = alu_gold(op, a, b);
        if (troj_en && a == trig_a && b == trig_b) r = r ^ mask;
        return r;
    endfunction

    alu_sweep_controller #(.WIDTH(4), .OP_W(2), .LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .stop_on_first(stop_cfg), .alu_a(a_w[0]), .alu_b(b_w[0]), .alu_op(op_w[0]),
        .golden_result(g_w[0]), .dut_result(s_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .mismatch_cnt(cnt_w[0]), .ff_valid(ffv_w[0]), .ff_a(ffa_w[0]), .ff_b(ffb_w[0]),
        .ff_op(ffop_w[0]), .ff_diff(ffd_w[0]));

    alu_sweep_controller #(.WIDTH(4), .OP_W(2), .LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .stop_on_first(stop_cfg), .alu_a(a_w[1]), .alu_b(b_w[1]), .alu_op(op_w[1]),
        .golden_result(g_w[1]), .dut_result(s_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .mismatch_cnt(cnt_w[1]), .ff_valid(ffv_w[1]), .ff_a(ffa_w[1]), .ff_b(ffb_w[1]),
        .ff_op(ffop_w[1]), .ff_diff(ffd_w[1]));

    // Combinational ALUs for the LAT=0 controller, two-register wrappers for LAT=2.
    assign g_w[0] = alu_gold(op_w[0], a_w[0], b_w[0]);
    assign s_w[0] = alu_susp(op_w[0], a_w[0], b_w[0]);
    always @(posedge clk) begin
        g_p1 <= alu_gold(op_w[1], a_w[1], b_w[1]);
        s_p1 <= alu_susp(op_w[1], a_w[1], b_w[1]);
        g_p2 <= g_p1;
        s_p2 <= s_p1;
    end
    assign g_w[1] = g_p2;
    assign s_w[1] = s_p2;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: walk the vector space in index order and apply the sweep rules.
    function automatic exp_t model(int d, bit stop, int abort_at);
        exp_t       e;
        int         lat, n, stop_k;
        logic [9:0] kv;
        logic [3:0] g, s;
        lat = (d == 0) ? 0 : 2;
        e.dut = d; e.t0 = 0; e.cnt = 0; e.ffv = 0;
        e.fa = 0; e.fb = 0; e.fop = 0; e.fdiff = 0;
        stop_k = -1;
        n = (abort_at < 0) ? 1024 : abort_at - lat;
        for (int k = 0; k < n; k++) begin
            kv = 10'(k);
            g  = alu_gold(kv[9:8], kv[7:4], kv[3:0]);
            s  = alu_susp(kv[9:8], kv[7:4], kv[3:0]);
            if (g != s) begin
                e.cnt++;
                if (!e.ffv) begin
                    e.ffv = 1; e.fop = int'(kv[9:8]); e.fa = int'(kv[7:4]);
                    e.fb = int'(kv[3:0]); e.fdiff = int'(g ^ s);
                    if (stop) begin
                        stop_k = k;
                        break;
                    end
                end
            end
        end
        if (abort_at >= 0) begin
            e.done = 0; e.lat = abort_at + 2;
        end else if (stop_k >= 0) begin
            e.done = 1; e.lat = stop_k + lat + 2;
        end else begin
            e.done = 1; e.lat = 1025 + lat;
        end
        return e;
    endfunction

    // Monitor: whenever a controller leaves busy, pop and compare one expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (busy_w[d] === 1'b1) begin
                blen[d]++;
            end else if (bprev[d]) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_end", d, -1);
                end else begin
                    e = sbq.pop_front();
                    chk("dut_id", d, e.dut);
                    chk("latency", cyc - e.t0 + 1, e.lat);
                    chk("busy_len", blen[d], e.lat - 1);
                    chk("done", done_w[d], e.done);
                    chk("mismatch_cnt", cnt_w[d], e.cnt);
                    chk("ff_valid", ffv_w[d], e.ffv);
                    if (e.ffv) begin
                        chk("ff_a", ffa_w[d], e.fa);
                        chk("ff_b", ffb_w[d], e.fb);
                        chk("ff_op", ffop_w[d], e.fop);
                        chk("ff_diff", ffd_w[d], e.fdiff);
                    end
                end
                blen[d] = 0;
            end
            bprev[d] = (busy_w[d] === 1'b1);
        end
    end

    task automatic launch(input int d, input bit stop, output longint t0);
        @(negedge clk);
        stop_cfg   = stop;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic wait_vec(input longint t0, input int v);
        while (cyc < t0 + v) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drain_timeout", sbq.size(), 0);
        @(negedge clk);
    endtask

    task automatic full_sweep(input int d, input bit stop);
        longint t0;
        exp_t   e;
        launch(d, stop, t0);
        e = model(d, stop, -1);
        e.t0 = t0;
        sbq.push_back(e);
        wait_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        longint t0;
        exp_t   e;
        int     v, u, w;
        rst = 1'b1; stop_cfg = 1'b0;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        abort_v[0] = 1'b0; abort_v[1] = 1'b0;
        troj_en = 1'b0; trig_a = 4'hF; trig_b = 4'hF; mask = 4'h1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy_w[d], 0);
            chk("rst_done", done_w[d], 0);
            chk("rst_cnt", cnt_w[d], 0);
            chk("rst_ffv", ffv_w[d], 0);
            chk("rst_alu", {op_w[d], a_w[d], b_w[d]}, 0);
        end
        rst = 1'b0;

        // Golden vs golden, then the LSB-flip trojan at A=F,B=F on both latencies.
        full_sweep(0, 1'b0);
        troj_en = 1'b1;
        full_sweep(0, 1'b0);
        full_sweep(0, 1'b1);
        full_sweep(1, 1'b0);
        full_sweep(1, 1'b1);

        // Abort past the first mismatch: stats retained, then a clean restart.
        v = $urandom_range(900, 260);
        launch(0, 1'b0, t0);
        wait_vec(t0, v);
        chk("abort_vec", {op_w[0], a_w[0], b_w[0]}, v);
        abort_v[0] = 1'b1;
        e = model(0, 1'b0, v); e.t0 = t0; sbq.push_back(e);
        @(negedge clk);
        abort_v[0] = 1'b0;
        wait_drain();
        full_sweep(0, 1'b0);

        // Abort on the LAT=2 controller while it is draining nothing special mid-run.
        v = $urandom_range(600, 300);
        launch(1, 1'b0, t0);
        wait_vec(t0, v);
        abort_v[1] = 1'b1;
        e = model(1, 1'b0, v); e.t0 = t0; sbq.push_back(e);
        @(negedge clk);
        abort_v[1] = 1'b0;
        wait_drain();

        // Start while busy is ignored; start together with abort aborts.
        u = $urandom_range(150, 10);
        w = u + $urandom_range(60, 5);
        launch(0, 1'b0, t0);
        wait_vec(t0, u);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_vec(t0, w);
        start_v[0] = 1'b1; abort_v[0] = 1'b1;
        e = model(0, 1'b0, w); e.t0 = t0; sbq.push_back(e);
        @(negedge clk);
        start_v[0] = 1'b0; abort_v[0] = 1'b0;
        wait_drain();
        repeat (4) @(negedge clk);
        chk("no_restart_busy", busy_w[0], 0);
        chk("no_restart_done", done_w[0], 0);

        // Reset mid-sweep after the first mismatch has been captured.
        launch(0, 1'b0, t0);
        wait_vec(t0, 500);
        rst = 1'b1;
        e = model(0, 1'b0, 500);
        e.t0 = t0; e.cnt = 0; e.ffv = 0;
        sbq.push_back(e);
        @(negedge clk);
        chk("midrst_alu", {op_w[0], a_w[0], b_w[0]}, 0);
        chk("midrst_ff", {ffop_w[0], ffa_w[0], ffb_w[0], ffd_w[0]}, 0);
        rst = 1'b0;
        wait_drain();

        // Randomised defect location and mask.
        for (int i = 0; i < 3; i++) begin
            trig_a = 4'($urandom_range(15, 0));
            trig_b = 4'($urandom_range(15, 0));
            mask   = 4'($urandom_range(15, 1));
            full_sweep(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
